// File: rtl/npc_pkg.sv
// Shared fetch-path types and constants.
// Imported by the fetch queue, its pointer sub-module and its interface.
package npc_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode queue bus: enqueue side, dequeue side, flush, occupancy.
// slave is the queue itself, master is the fetch/decode/execute side.
interface inst_fetch_queue_if
  import npc_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            flush;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid,
    input  in_pc,
    input  in_inst,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output out_pc,
    output out_inst,
    output count
  );

  modport master (
    output in_valid,
    output in_pc,
    output in_inst,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  out_pc,
    input  out_inst,
    input  count
  );

endinterface

// File: rtl/fq_ptr.sv
// Wrap-bit queue pointer: clear beats load beats increment.
// The extra MSB distinguishes full from empty when indices match.
module fq_ptr #(
  parameter int AW = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        load,
  input  logic [AW:0] load_val,
  input  logic        clear,
  output logic [AW:0] ptr
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between fetch and decode, flushed on redirect.
// Head is read combinationally from storage; no enqueue bypass.
module inst_fetch_queue
  import npc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clock,
  input logic               reset_n,
  inst_fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  fetch_pkt_t  head;
  fetch_pkt_t  mem [DEPTH];

  assign empty = rd_ptr == wr_ptr;
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0])
              && (rd_ptr[AW] != wr_ptr[AW]);

  // Flush wins: anything offered alongside it is dropped.
  assign push = bus.in_valid && !full && !bus.flush;
  assign pop  = bus.out_ready && !empty && !bus.flush;

  assign head = mem[rd_ptr[AW-1:0]];

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = empty ? '0 : head.pc;
  assign bus.out_inst  = empty ? INST_NOP : head.inst;
  assign bus.count     = wr_ptr - rd_ptr;

  fq_ptr #(.AW(AW)) u_rd (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      (pop),
    .load     (bus.flush),
    .load_val (wr_ptr),
    .clear    (1'b0),
    .ptr      (rd_ptr)
  );

  fq_ptr #(.AW(AW)) u_wr (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      (push),
    .load     (1'b0),
    .load_val (wr_ptr),
    .clear    (1'b0),
    .ptr      (wr_ptr)
  );

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: bus.in_pc, inst: bus.in_inst};
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus a random run
// checked every cycle against a queue-based model.
module tb_inst_fetch_queue;
  import npc_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [XLEN+ILEN-1:0] mq[$];

  always #5 clock = ~clock;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: a plain FIFO of {pc,inst}, flush empties it.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      logic do_pop;
      logic do_push;
      do_pop  = bus.out_ready && mq.size() != 0;
      do_push = bus.in_valid && mq.size() != DEPTH;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({bus.in_pc, bus.in_inst});
    end
  end

  always @(negedge clock) begin
    if (run && reset_n) begin
      logic [XLEN+ILEN-1:0] hd;
      hd = (mq.size() != 0) ? mq[0] : {64'h0, INST_NOP};
      chk("m_out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("m_in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
      chk("m_count", 64'(bus.count), 64'(mq.size()));
      chk("m_out_pc", bus.out_pc, hd[XLEN+ILEN-1:ILEN]);
      chk("m_out_inst", 64'(bus.out_inst), 64'(hd[ILEN-1:0]));
    end
  end

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic drain();
    idle();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] pc;
    bus.in_pc   = '0;
    bus.in_inst = '0;
    idle();

    // 1: reset with in_valid held
    bus.in_valid = 1'b1;
    bus.in_pc    = RESET_PC;
    repeat (2) step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'h13);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    idle();
    reset_n = 1'b1;
    run     = 1'b1;
    step();

    // 2: fill to full, fifth push ignored, drain in order
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = RESET_PC + 64'(4 * i);
      bus.in_inst  = 32'h1000_0000 + 32'(i);
      step();
    end
    idle();
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_pc", bus.out_pc, RESET_PC + 64'(4 * i));
      chk("pop_inst", 64'(bus.out_inst), 64'(32'h1000_0000 + 32'(i)));
      step();
    end
    chk("pop_empty", 64'(bus.out_valid), 64'd0);
    idle();

    // 3: steady stream, occupancy 1, pointers wrap
    pc = RESET_PC + 64'h40;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = pc + 64'(4 * i);
      bus.in_inst  = 32'(i) ^ 32'h00A0_0000;
      step();
      chk("strm_count", 64'(bus.count), 64'd1);
      chk("strm_pc", bus.out_pc, pc + 64'(4 * i));
    end
    drain();

    // 4: flush at count 3 drops concurrent push
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = RESET_PC + 64'h80 + 64'(4 * i);
      bus.in_inst  = 32'h0000_0093;
      step();
    end
    idle();
    chk("pre_flush_count", 64'(bus.count), 64'd3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = RESET_PC + 64'h100;
    step();
    idle();
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("flush_no_enq", 64'(bus.out_valid), 64'd0);

    // 5: async reset mid-cycle at count 2
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = RESET_PC + 64'h200 + 64'(4 * i);
      step();
    end
    idle();
    chk("pre_rst_count", 64'(bus.count), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_pc", bus.out_pc, 64'd0);
    chk("arst_inst", 64'(bus.out_inst), 64'h13);
    step();
    reset_n = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_pc    = RESET_PC + 64'h300;
    bus.in_inst  = 32'hCAFE_0013;
    #1;
    chk("no_bypass", 64'(bus.out_valid), 64'd0);
    step();
    idle();
    chk("post_rst_pc", bus.out_pc, RESET_PC + 64'h300);
    chk("post_rst_inst", 64'(bus.out_inst), 64'hCAFE_0013);
    drain();

    // 6: random traffic with occasional flush
    pc = RESET_PC + 64'h1000;
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush     = $urandom_range(0, 99) < 5;
      bus.in_pc     = pc;
      bus.in_inst   = $urandom;
      pc            = pc + 64'd4;
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
